// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;
  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;
  localparam int CW_DEF = $clog2(DW_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/divider_seq_if.sv
// Start/done handshake and operand/result bus for divider_seq.
interface divider_seq_if #(
  parameter int DW = 8,
  parameter int VW = 4
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          busy;
  logic          done;
  logic          dz;
  logic          chk_err;

  modport master (output start, dividend, divisor,
                  input  quotient, remainder, busy, done, dz, chk_err);
  modport slave  (input  start, dividend, divisor,
                  output quotient, remainder, busy, done, dz, chk_err);
endinterface

// File: rtl/divider_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial subtract.
module divider_step #(
  parameter int VW = 4
) (
  input  logic [VW:0]   r_i,
  input  logic          bit_i,
  input  logic [VW-1:0] dvs_i,
  output logic [VW:0]   r_o,
  output logic          q_o
);
  logic [VW:0] r_sh;
  logic        unused_msb;

  // R stays below the divisor, so its top bit is always zero going in.
  assign unused_msb = r_i[VW];
  assign r_sh       = {r_i[VW-1:0], bit_i};
  assign q_o        = (r_sh >= {1'b0, dvs_i});
  assign r_o        = q_o ? (r_sh - {1'b0, dvs_i}) : r_sh;
endmodule

// File: rtl/divider_seq.sv
// Sequential restoring divider, one quotient bit per clock, start/done handshake.
// Optional result self-check enabled by defining DIVIDER_SELFCHECK_EN.
module divider_seq
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  divider_seq_if.slave bus
);
  localparam int CW = $clog2(DW);

  state_e        state_q;
  logic [DW-1:0] dvd_q, q_q, quotient_q;
  logic [VW-1:0] dvs_q, remainder_q;
  logic [VW:0]   r_q, r_d;
  logic [CW-1:0] cnt_q;
  logic          done_q, dz_q, q_bit;
  logic [DW-1:0] q_d;

  divider_step #(.VW(VW)) u_step (
    .r_i   (r_q),
    .bit_i (dvd_q[DW-1]),
    .dvs_i (dvs_q),
    .r_o   (r_d),
    .q_o   (q_bit)
  );

  assign q_d = {q_q[DW-2:0], q_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      r_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          if (bus.divisor == '0) begin
            quotient_q  <= '1;
            remainder_q <= '0;
            dz_q        <= 1'b1;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end else begin
            dvd_q   <= bus.dividend;
            dvs_q   <= bus.divisor;
            r_q     <= '0;
            q_q     <= '0;
            cnt_q   <= CW'(DW-1);
            dz_q    <= 1'b0;
            state_q <= CALC;
          end
        end
        CALC: begin
          r_q   <= r_d;
          dvd_q <= {dvd_q[DW-2:0], 1'b0};
          q_q   <= q_d;
          cnt_q <= cnt_q - CW'(1);
          // Last iteration: publish results straight from the step outputs.
          if (cnt_q == '0) begin
            quotient_q  <= q_d;
            remainder_q <= r_d[VW-1:0];
            done_q      <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.dz        = dz_q;

`ifdef DIVIDER_SELFCHECK_EN
  localparam int PW = DW + VW;
  logic [DW-1:0] dvd_cap_q;
  logic [PW-1:0] recon;
  logic          chk_fail, chk_err_q;

  assign recon    = PW'(quotient_q) * PW'(dvs_q) + PW'(remainder_q);
  assign chk_fail = (state_q == DONE) && !dz_q &&
                    ((recon != PW'(dvd_cap_q)) || (remainder_q >= dvs_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_cap_q <= '0;
      chk_err_q <= 1'b0;
    end else if (state_q == IDLE && bus.start) begin
      dvd_cap_q <= bus.dividend;
      chk_err_q <= 1'b0;
    end else if (chk_fail) begin
      chk_err_q <= 1'b1;
    end
  end

  assign bus.chk_err = chk_err_q;
`else
  assign bus.chk_err = 1'b0;
`endif
endmodule
